passthru_arbiter: RTL and testbench
===================================

PASSTHRU_ARBITER -- requirements
Module: passthru_arbiter

Interface
REQ-001 Parameter WIDTH, default 2: data width of each requester and of the output channel.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..16.
REQ-003 Parameter MAX_BURST, default 2: maximum beats per grant, legal range 1..16.
REQ-004 Localparam IDW = max(1, clog2(NREQ)), declared in the ANSI parameter port list, not overridable.
REQ-005 Port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port RST  input  1  reset; asynchronous, active-high.
REQ-007 Port req_valid  input  NREQ  per-requester valid; bit i belongs to requester i.
REQ-008 Port req_data  input  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port req_ready  output  NREQ  per-requester ready.
REQ-010 Port out_valid  output  1  shared channel valid.
REQ-011 Port out_ready  input  1  shared channel ready from the downstream datapath.
REQ-012 Port out_data  output  WIDTH  shared channel data.
REQ-013 Port out_id  output  IDW  index of the granted requester.

Function
REQ-014 FSM states: IDLE and BUSY; registers gnt (IDW bits), rr_ptr (IDW bits) and cnt (beat counter, clog2(MAX_BURST+1) bits).
REQ-015 IDLE, any req_valid set: select the first set bit at or after rr_ptr, rotating upward and wrapping NREQ-1 -> 0; load gnt; clear cnt; go to BUSY.
REQ-016 IDLE, no req_valid set: stay in IDLE; gnt, rr_ptr and cnt hold.
REQ-017 BUSY: out_valid = req_valid[gnt]; out_data = req_data[gnt]; out_id = gnt; req_ready[gnt] = out_ready; all other req_ready bits are 0.
REQ-018 Not BUSY: out_valid = 0, out_data = 0, out_id = 0, req_ready = 0.
REQ-019 A transfer is out_valid and out_ready in the same cycle; each transfer increments cnt.
REQ-020 Transfer with cnt == MAX_BURST-1: next state IDLE, rr_ptr <= (gnt+1) mod NREQ.
REQ-021 BUSY with req_valid[gnt] low: next state IDLE, rr_ptr <= (gnt+1) mod NREQ (grant released, no transfer).
REQ-022 BUSY with out_ready low: out_data and out_id held stable; cnt and gnt unchanged.
REQ-023 Arbitration costs exactly one IDLE cycle between grants; the first beat can be delivered in the cycle after the grant decision.
REQ-024 Requests from non-granted requesters never affect the current burst; they are considered only at the next IDLE decision.
REQ-025 Combinational paths are limited to req_* -> out_* and out_ready -> req_ready; no path runs from out_ready to out_valid.

Reset
REQ-026 While RST is high: state = IDLE, gnt = 0, rr_ptr = 0, cnt = 0, so all outputs take their REQ-018 values immediately, without waiting for CLK.
REQ-027 RST asserted mid-burst abandons the burst; after release, arbitration restarts from rr_ptr = 0.

Structure
REQ-028 Shared package arb_pkg holds the state encoding (IDLE = 0, BUSY = 1) and the default values of WIDTH, NREQ and MAX_BURST.
REQ-029 Sub-module rr_pick: a purely combinational rotating-priority encoder with inputs (req vector, rr_ptr) and outputs (any, index), instantiated once.

Verification (NREQ=4, WIDTH=2, MAX_BURST=2)
REQ-030 Requester 1 presents continuous valid with data 01, 10, 11 and out_ready=1: beats 01 and 10 with out_id=1, then 1 IDLE cycle, then beat 11 with out_id=1; rr_ptr=2 after the first release.
REQ-031 All four requesters continuously valid, out_ready=1: grant order 0,1,2,3,0, two beats each, one idle cycle between grants.
REQ-032 Requester 2 granted, out_ready low for 3 cycles mid-burst: out_data and out_id stable, cnt unchanged, burst resumes when out_ready rises.
REQ-033 rr_ptr=3 after a release, requesters 0 and 2 valid: next grant is 0, then 2.
REQ-034 Granted requester 0 drops valid after one beat: FSM returns to IDLE the next cycle, rr_ptr=1, no extra transfer.
REQ-035 RST pulsed asynchronously mid-burst (between clock edges): all outputs read 0 immediately; after release, first grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg
//   Shared definitions for the pass-through arbiter: the two-state FSM
//   encoding, the default sizes of the arbiter, and a small helper for
//   advancing a requester index with wrap-around.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 2;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 2;

  // Index of the requester after idx, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Purely combinational rotating-priority encoder. Finds the first set bit
//   of req at or after position rr_ptr, scanning upward and wrapping from
//   NREQ-1 to 0.
// Ports
//   req     in   NREQ  request vector
//   rr_ptr  in   IDW   position with highest priority
//   any     out  1     at least one request bit is set
//   index   out  IDW   index of the selected request (0 when any is low)
module rr_pick
  import arb_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            any,
  output logic [IDW-1:0]  index
);

  // Scan from the lowest priority offset to the highest so that the last
  // hit written is the one closest to rr_ptr; no early exit is needed.
  always_comb begin
    logic [IDW-1:0] cand;
    cand  = '0;
    any   = 1'b0;
    index = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req[cand]) begin
        any   = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/passthru_arbiter.sv
// passthru_arbiter
//   Round-robin arbiter that passes one requester's valid/data stream
//   straight through to a shared output channel for bursts of up to
//   MAX_BURST beats. One IDLE cycle is spent on each grant decision.
// Ports
//   CLK        in   1           clock, rising edge
//   RST        in   1           asynchronous active-high reset
//   req_valid  in   NREQ        per-requester valid
//   req_data   in   NREQ*WIDTH  per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  NREQ        per-requester ready (only the granted bit can be set)
//   out_valid  out  1           shared channel valid
//   out_ready  in   1           shared channel ready
//   out_data   out  WIDTH       shared channel data
//   out_id     out  IDW         index of the granted requester
module passthru_arbiter
  import arb_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  NREQ      = DEF_NREQ,
  parameter int  MAX_BURST = DEF_MAX_BURST,
  localparam int IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id
);

  localparam int              CNTW      = $clog2(MAX_BURST + 1);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAX_BURST - 1);

  state_t          state_q, state_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  next_ptr;
  logic [WIDTH-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_split
    assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Priority rotates to the requester just after the one being released.
  assign next_ptr = IDW'(wrap_inc(int'(gnt_q), NREQ));

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req   (req_valid),
    .rr_ptr(rr_ptr_q),
    .any   (pick_any),
    .index (pick_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // A granted requester that drops valid gives up the rest of its burst;
  // otherwise the burst ends on the transfer of beat MAX_BURST.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req_valid[gnt_q]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (out_ready) begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // out_valid depends only on req_valid and the registered grant, never on
  // out_ready, so downstream can derive ready from valid without a loop.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_id    = '0;
    req_ready = '0;
    if (state_q == BUSY) begin
      out_valid        = req_valid[gnt_q];
      out_data         = data_arr[gnt_q];
      out_id           = gnt_q;
      req_ready[gnt_q] = out_ready;
    end
  end

endmodule

// File: tb/tb_passthru_arbiter.sv
// tb_passthru_arbiter
//   Bench for passthru_arbiter with NREQ=4, WIDTH=2, MAX_BURST=2. A
//   transaction-level reference (current owner, beats delivered, rotation
//   pointer) predicts the outputs every cycle; directed scenarios add
//   fixed expectations for grant order, timing and reset behaviour.
module tb_passthru_arbiter;
  import arb_pkg::*;

  localparam int WIDTH     = 2;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 2;
  localparam int IDW       = 2;

  logic                  CLK;
  logic                  RST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;

  int n_total;
  int n_bad;

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_beats;

  logic [8:0] exp_bus;
  logic [8:0] obs_bus;
  logic [3:0] obs_log[$];

  assign obs_bus = {out_valid, out_id, out_data, req_ready};

  passthru_arbiter #(
    .WIDTH    (WIDTH),
    .NREQ     (NREQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_beats = 0;
    obs_log.delete();
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic model_expect();
    logic [NREQ-1:0]  rdy;
    logic [WIDTH-1:0] dat;
    rdy = '0;
    if (m_busy) begin
      rdy[IDW'(m_owner)] = out_ready;
      dat     = WIDTH'(req_data >> (m_owner * WIDTH));
      exp_bus = {req_valid[IDW'(m_owner)], IDW'(m_owner), dat, rdy};
    end else begin
      exp_bus = '0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit found;
    int idx;
    found = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (!found && req_valid[IDW'(idx)]) begin
          found   = 1'b1;
          m_owner = idx;
        end
      end
      if (found) begin
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!req_valid[IDW'(m_owner)]) begin
      m_busy = 1'b0;
      m_ptr  = (m_owner + 1) % NREQ;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == MAX_BURST) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic advance();
    if (out_valid && out_ready) obs_log.push_back({out_id, out_data});
    model_step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    #2;
    RST = 1'b0;
    model_clear();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1;
    RST       = 1'b1;
    req_valid = '1;
    req_data  = 8'hFF;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (obs_bus !== 9'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", obs_bus, 9'd0);
    end
    n_total++;
    if ({1'(dut.state_q), dut.gnt_q, dut.rr_ptr_q, dut.cnt_q} !== 7'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_regs got=%b want=%b",
               {1'(dut.state_q), dut.gnt_q, dut.rr_ptr_q, dut.cnt_q}, 7'd0);
    end
    req_valid = '0;
    out_ready = 1'b0;
    #1;
    RST = 1'b0;
    model_clear();
    @(negedge CLK);
  endtask

  task automatic test_single_stream();
    logic [1:0]  seq [3];
    logic [4:0]  vpat;
    logic [11:0] got;
    int          pos;
    seq  = '{2'b01, 2'b10, 2'b11};
    pos  = 0;
    vpat = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b0010;
      req_data  = 8'(seq[(pos < 3) ? pos : 2]) << 2;
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL stream_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      vpat[c] = out_valid;
      if (c == 3) begin
        n_total++;
        if (dut.rr_ptr_q !== 2'd2) begin
          n_bad++;
          $display("[TB] FAIL stream_rr_ptr got=%0d want=2", dut.rr_ptr_q);
        end
      end
      if (exp_bus[8] && out_ready) pos++;
      advance();
    end
    n_total++;
    if (vpat !== 5'b10110) begin
      n_bad++;
      $display("[TB] FAIL stream_timing got=%b want=%b", vpat, 5'b10110);
    end
    for (int i = 0; i < 3; i++) got[11 - 4*i -: 4] = (i < obs_log.size()) ? obs_log[i] : 4'bxxxx;
    n_total++;
    if (obs_log.size() != 3 || got !== {4'b0101, 4'b0110, 4'b0111}) begin
      n_bad++;
      $display("[TB] FAIL stream_beats got=%h (n=%0d) want=567 (n=3)", got, obs_log.size());
    end
  endtask

  task automatic test_all_valid();
    logic [14:0] vpat;
    logic [19:0] got;
    do_reset();
    vpat = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      req_valid = '1;
      req_data  = 8'($urandom);
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL allvalid_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      vpat[c] = out_valid;
      advance();
    end
    n_total++;
    if (vpat !== 15'b110110110110110) begin
      n_bad++;
      $display("[TB] FAIL allvalid_timing got=%b want=%b", vpat, 15'b110110110110110);
    end
    for (int i = 0; i < 10; i++) got[19 - 2*i -: 2] = (i < obs_log.size()) ? obs_log[i][3:2] : 2'bxx;
    n_total++;
    if (obs_log.size() != 10 ||
        got !== {2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0}) begin
      n_bad++;
      $display("[TB] FAIL allvalid_order got=%b (n=%0d) want=%b", got, obs_log.size(),
               {2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0});
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] slot2;
    logic [7:0] got;
    do_reset();
    slot2 = 2'($urandom);
    for (int c = 0; c < 7; c++) begin
      req_valid = 4'b0100;
      req_data  = (8'($urandom) & 8'hCF) | (8'(slot2) << 4);
      out_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL stall_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      if (c >= 2 && c <= 4) begin
        n_total++;
        if ({out_valid, out_id, out_data, dut.cnt_q} !== {1'b1, 2'd2, slot2, 2'd1}) begin
          n_bad++;
          $display("[TB] FAIL stall_hold_cyc%0d got=%b want=%b", c,
                   {out_valid, out_id, out_data, dut.cnt_q}, {1'b1, 2'd2, slot2, 2'd1});
        end
      end
      advance();
    end
    for (int i = 0; i < 2; i++) got[7 - 4*i -: 4] = (i < obs_log.size()) ? obs_log[i] : 4'bxxxx;
    n_total++;
    if (obs_log.size() != 2 || got !== {2'd2, slot2, 2'd2, slot2}) begin
      n_bad++;
      $display("[TB] FAIL stall_beats got=%h (n=%0d) want=%h (n=2)", got, obs_log.size(),
               {2'd2, slot2, 2'd2, slot2});
    end
  endtask

  task automatic test_ptr_wrap();
    logic [11:0] got;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 3) ? 4'b0100 : 4'b0101;
      req_data  = 8'($urandom);
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL wrap_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      if (c == 3) begin
        n_total++;
        if (dut.rr_ptr_q !== 2'd3) begin
          n_bad++;
          $display("[TB] FAIL wrap_rr_ptr got=%0d want=3", dut.rr_ptr_q);
        end
      end
      advance();
    end
    for (int i = 0; i < 6; i++) got[11 - 2*i -: 2] = (i < obs_log.size()) ? obs_log[i][3:2] : 2'bxx;
    n_total++;
    if (obs_log.size() != 6 || got !== {2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2}) begin
      n_bad++;
      $display("[TB] FAIL wrap_order got=%b (n=%0d) want=%b", got, obs_log.size(),
               {2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2});
    end
  endtask

  task automatic test_drop_valid();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req_valid = (c == 2) ? 4'b0000 : 4'b0001;
      req_data  = 8'($urandom);
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL drop_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      if (c == 3) begin
        n_total++;
        if ({1'(dut.state_q), dut.rr_ptr_q} !== {1'(IDLE), 2'd1}) begin
          n_bad++;
          $display("[TB] FAIL drop_release got=%b want=%b",
                   {1'(dut.state_q), dut.rr_ptr_q}, {1'(IDLE), 2'd1});
        end
        n_total++;
        if (obs_log.size() != 1) begin
          n_bad++;
          $display("[TB] FAIL drop_beats got=%0d want=1", obs_log.size());
        end
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] got;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_valid = '1;
      req_data  = 8'($urandom);
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL areset_pre_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      if (c < 4) advance();
    end
    #2;
    RST = 1'b1;
    #1;
    n_total++;
    if ({obs_bus, dut.rr_ptr_q} !== 11'd0) begin
      n_bad++;
      $display("[TB] FAIL areset_immediate got=%b want=%b", {obs_bus, dut.rr_ptr_q}, 11'd0);
    end
    @(posedge CLK);
    #1;
    n_total++;
    if (obs_bus !== 9'd0) begin
      n_bad++;
      $display("[TB] FAIL areset_held got=%b want=%b", obs_bus, 9'd0);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b1001;
      req_data  = 8'($urandom);
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL areset_post_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      advance();
    end
    for (int i = 0; i < 2; i++) got[3 - 2*i -: 2] = (i < obs_log.size()) ? obs_log[i][3:2] : 2'bxx;
    n_total++;
    if (obs_log.size() != 2 || got !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL areset_first_grant got=%b (n=%0d) want=0000 (n=2)", got, obs_log.size());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      req_data  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      n_total++;
      if (obs_bus !== exp_bus) begin
        n_bad++;
        $display("[TB] FAIL random_cyc%0d got=%b want=%b", c, obs_bus, exp_bus);
      end
      advance();
    end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    RST       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single_stream();
    test_all_valid();
    test_backpressure();
    test_ptr_wrap();
    test_drop_valid();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
